// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: measures VGA sync timing (line period, hsync width,
// lines per frame, vsync width) and a rotate-XOR signature of the active
// pixels for a programmable number of frames after a start pulse.
module vga_frame_monitor #(
  parameter int H_TOTAL  = 1056,
  parameter int V_TOTAL  = 628,
  parameter int HS_WIDTH = 128,
  parameter int VS_WIDTH = 4,
  parameter int H_START  = 216,
  parameter int H_ACTIVE = 800,
  parameter int V_START  = 28,
  parameter int V_ACTIVE = 600,
  parameter int COLOR_W  = 4,
  parameter int SYNC_POL = 0,
  parameter int N_FRAMES = 2
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               start,
  input  logic               hs,
  input  logic               vs,
  input  logic [COLOR_W-1:0] r,
  input  logic [COLOR_W-1:0] g,
  input  logic [COLOR_W-1:0] b,
  output logic               frame_valid,
  output logic [7:0]         frame_cnt,
  output logic [15:0]        hperiod,
  output logic [15:0]        hswidth,
  output logic [15:0]        lines,
  output logic [15:0]        vswidth,
  output logic [31:0]        checksum,
  output logic [3:0]         err,
  output logic               busy,
  output logic               done
);

  localparam logic        POL    = SYNC_POL[0];
  localparam logic [15:0] HT16   = 16'(H_TOTAL);
  localparam logic [15:0] VT16   = 16'(V_TOTAL);
  localparam logic [15:0] HSW16  = 16'(HS_WIDTH);
  localparam logic [15:0] VSW16  = 16'(VS_WIDTH);
  localparam logic [15:0] HLO16  = 16'(H_START);
  localparam logic [15:0] HHI16  = 16'(H_START + H_ACTIVE);
  localparam logic [15:0] VLO16  = 16'(V_START);
  localparam logic [15:0] VHI16  = 16'(V_START + V_ACTIVE);
  localparam logic [7:0]  NFR8   = 8'(N_FRAMES);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_e;

  state_e      state_q;
  logic        hs_q, vs_q;
  logic        hs_seen_q;
  logic [15:0] hcnt_q, line_q, hsp_q, vsl_q;
  logic [31:0] sig_q;
  logic        frame_valid_q, busy_q, done_q;
  logic [7:0]  frame_cnt_q;
  logic [15:0] hperiod_q, hswidth_q, lines_q, vswidth_q;
  logic [31:0] checksum_q;
  logic [3:0]  err_q;

  logic        hs_a, vs_a, hs_lead, hs_trail, vs_lead, vs_trail, pix_act, run;
  logic [15:0] hcnt_d, line_d, hsp_d, vsl_d, hper_d;
  logic [31:0] sig_d;
  logic [7:0]  fcnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Edge detection, active-window decode and next values of the free counters
  always_comb begin
    hs_a     = (hs == POL);
    vs_a     = (vs == POL);
    hs_lead  = hs_a & ~hs_q;
    hs_trail = ~hs_a & hs_q;
    vs_lead  = vs_a & ~vs_q;
    vs_trail = ~vs_a & vs_q;
    run      = (state_q == ARM) || (state_q == MEAS);
    pix_act  = (hcnt_q >= HLO16) && (hcnt_q < HHI16) &&
               (line_q >= VLO16) && (line_q < VHI16);
    sig_d    = pix_act ? ({sig_q[30:0], sig_q[31]} ^ 32'({r, g, b})) : sig_q;
    hcnt_d   = hs_lead ? 16'd0 : sat_inc(hcnt_q);
    hper_d   = sat_inc(hcnt_q);
    hsp_d    = hs_lead ? 16'd1 : (hs_a ? sat_inc(hsp_q) : hsp_q);
    if (vs_lead)      line_d = hs_lead ? 16'd1 : 16'd0;
    else if (hs_lead) line_d = sat_inc(line_q);
    else              line_d = line_q;
    if (vs_lead)              vsl_d = hs_lead ? 16'd1 : 16'd0;
    else if (vs_a && hs_lead) vsl_d = sat_inc(vsl_q);
    else                      vsl_d = vsl_q;
    fcnt_d   = frame_cnt_q + 8'd1;
  end

  // Measurement FSM; counters only advance in ARM/MEAS, results only in MEAS
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= IDLE;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      hs_seen_q     <= 1'b0;
      hcnt_q        <= '0;
      line_q        <= '0;
      hsp_q         <= '0;
      vsl_q         <= '0;
      sig_q         <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_cnt_q   <= '0;
      hperiod_q     <= '0;
      hswidth_q     <= '0;
      lines_q       <= '0;
      vswidth_q     <= '0;
      checksum_q    <= '0;
      err_q         <= '0;
    end else begin
      hs_q          <= hs_a;
      vs_q          <= vs_a;
      frame_valid_q <= 1'b0;
      if (start) begin
        // edge history keeps sampling so a coincident sync edge is consumed
        state_q     <= ARM;
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
        err_q       <= '0;
        frame_cnt_q <= '0;
        checksum_q  <= '0;
        hcnt_q      <= '0;
        line_q      <= '0;
        hsp_q       <= '0;
        vsl_q       <= '0;
        sig_q       <= '0;
        hs_seen_q   <= 1'b0;
      end else if (run) begin
        hcnt_q <= hcnt_d;
        line_q <= line_d;
        hsp_q  <= hsp_d;
        vsl_q  <= vsl_d;
        sig_q  <= vs_lead ? 32'd0 : sig_d;
        case (state_q)
          ARM: begin
            if (vs_lead) begin
              state_q   <= MEAS;
              hs_seen_q <= 1'b0;
            end
          end
          MEAS: begin
            if (hs_lead) begin
              hs_seen_q <= 1'b1;
              // the first line edge in MEAS has no trustworthy start point
              if (hs_seen_q) begin
                hperiod_q <= hper_d;
                if (hper_d != HT16) err_q[0] <= 1'b1;
              end
            end
            if (hs_trail) begin
              hswidth_q <= hsp_q;
              if (hsp_q != HSW16) err_q[1] <= 1'b1;
            end
            if (vs_trail) begin
              vswidth_q <= vsl_q;
              if (vsl_q != VSW16) err_q[3] <= 1'b1;
            end
            if (vs_lead) begin
              lines_q       <= line_q;
              if (line_q != VT16) err_q[2] <= 1'b1;
              checksum_q    <= sig_d;
              frame_cnt_q   <= fcnt_d;
              frame_valid_q <= 1'b1;
              if (fcnt_d == NFR8) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_cnt   = frame_cnt_q;
  assign hperiod     = hperiod_q;
  assign hswidth     = hswidth_q;
  assign lines       = lines_q;
  assign vswidth     = vswidth_q;
  assign checksum    = checksum_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor: a small video timing keeps runs short; a
// frame-level reference model predicts every frame_valid record.
module tb_vga_frame_monitor;
  localparam int HT = 40, HSW = 6, HST = 10, HACT = 24;
  localparam int VT = 20, VSW = 3, VST = 5, VACT = 15;
  localparam int CW = 4, NF = 2, PXW = 3 * CW;
  localparam logic POL = 1'b0;

  logic pclk = 1'b0;
  logic rst, start, hs, vs;
  logic [CW-1:0] r, g, b;
  logic        frame_valid, busy, done;
  logic [7:0]  frame_cnt;
  logic [15:0] hperiod, hswidth, lines, vswidth;
  logic [31:0] checksum;
  logic [3:0]  err;

  vga_frame_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .HS_WIDTH(HSW), .VS_WIDTH(VSW),
    .H_START(HST), .H_ACTIVE(HACT), .V_START(VST), .V_ACTIVE(VACT),
    .COLOR_W(CW), .SYNC_POL(0), .N_FRAMES(NF)
  ) dut (
    .pclk(pclk), .rst(rst), .start(start), .hs(hs), .vs(vs),
    .r(r), .g(g), .b(b), .frame_valid(frame_valid), .frame_cnt(frame_cnt),
    .hperiod(hperiod), .hswidth(hswidth), .lines(lines), .vswidth(vswidth),
    .checksum(checksum), .err(err), .busy(busy), .done(done)
  );

  always #5 pclk = ~pclk;

  typedef struct { int n; int vsw; int hsw; int long_line; } fdesc_t;
  typedef struct {
    logic [15:0] hper, hsw, lines, vsw;
    logic [31:0] cks;
    logic [3:0]  err;
    logic [7:0]  cnt;
  } meas_t;
  typedef struct {
    fdesc_t f0, f1, f2;
    bit cpx;
    logic [3:0] e_err;
    logic [15:0] e_lines, e_vsw, e_hper, e_hsw;
  } scen_t;

  int checks = 0, errors = 0, fv_seen = 0;
  meas_t expq[$];
  logic [31:0] cks_hist[$];

  // reference model state: armed waits for a vsync, meas counts frames
  bit m_armed = 0, m_meas = 0, m_first = 0;
  logic [3:0] m_err = '0;
  int m_cnt = 0, m_last_len = 0;
  logic [31:0] m_sig = '0;
  fdesc_t m_cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every frame_valid pulse is compared with the model's next record
  always @(negedge pclk) begin
    if (frame_valid === 1'b1) begin
      fv_seen++;
      cks_hist.push_back(checksum);
      if (expq.size() == 0) check("fv_unexpected", 32'(frame_valid), 32'd0);
      else begin
        meas_t e;
        e = expq.pop_front();
        check("fv_lines", 32'(lines), 32'(e.lines));
        check("fv_hperiod", 32'(hperiod), 32'(e.hper));
        check("fv_hswidth", 32'(hswidth), 32'(e.hsw));
        check("fv_vswidth", 32'(vswidth), 32'(e.vsw));
        check("fv_err", 32'(err), 32'(e.err));
        check("fv_checksum", checksum, e.cks);
        check("fv_frame_cnt", 32'(frame_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int k);
    hs = ~POL; vs = ~POL; start = 1'b0;
    repeat (k) tick();
  endtask

  task automatic do_start();
    hs = ~POL; vs = ~POL; start = 1'b1;
    tick();
    start = 1'b0;
    m_armed = 1; m_meas = 0; m_err = '0; m_cnt = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fv"}, 32'(frame_valid), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_hperiod"}, 32'(hperiod), 32'd0);
    check({tag, "_hswidth"}, 32'(hswidth), 32'd0);
    check({tag, "_lines"}, 32'(lines), 32'd0);
    check({tag, "_vswidth"}, 32'(vswidth), 32'd0);
    check({tag, "_checksum"}, checksum, 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Drives one frame (each line starts with hsync, first vsw lines carry
  // vsync) and runs the frame-level model alongside
  task automatic drive_frame(input fdesc_t fd, input bit start_at0, input bit const_px);
    logic [PXW-1:0] px;
    int len;
    for (int l = 0; l < fd.n; l++) begin
      len = HT + ((l == fd.long_line) ? 1 : 0);
      for (int c = 0; c < len; c++) begin
        hs = (c < fd.hsw) ? POL : ~POL;
        vs = (l < fd.vsw) ? POL : ~POL;
        px = const_px ? {PXW{1'b1}} : PXW'($urandom);
        {r, g, b} = px;
        start = start_at0 && (l == 0) && (c == 0);
        if (l == 0 && c == 0) begin
          if (start_at0) begin
            m_armed = 1; m_meas = 0; m_err = '0; m_cnt = 0;
          end else if (m_meas) begin
            meas_t e;
            if (m_cur.n != VT) m_err[2] = 1'b1;
            if (m_cur.vsw != VSW) m_err[3] = 1'b1;
            if (m_cur.hsw != HSW) m_err[1] = 1'b1;
            m_cnt++;
            e.lines = 16'(m_cur.n); e.vsw = 16'(m_cur.vsw); e.hsw = 16'(m_cur.hsw);
            e.hper = 16'(m_last_len); e.err = m_err; e.cks = m_sig; e.cnt = 8'(m_cnt);
            expq.push_back(e);
            if (m_cnt == NF) m_meas = 0;
          end else if (m_armed) begin
            m_armed = 0; m_meas = 1; m_first = 1;
          end
          if (m_meas) begin m_cur = fd; m_sig = '0; end
        end
        // pixel position: columns counted from the cycle after hsync starts,
        // rows 1-based; the hsync cycle itself is never inside the window
        if (m_meas && c >= 1 && (c - 1) >= HST && (c - 1) < HST + HACT &&
            (l + 1) >= VST && (l + 1) < VST + VACT)
          m_sig = {m_sig[30:0], m_sig[31]} ^ 32'(px);
        tick();
      end
      if (m_meas) begin
        if (!m_first && len != HT) m_err[0] = 1'b1;
        m_first = 0;
        m_last_len = len;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_final(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(NF));
    check({tag, "_pending"}, 32'(expq.size()), 32'd0);
  endtask

  scen_t tbl[7];
  fdesc_t nom, fx[3];
  logic [31:0] cref;
  int fv0;

  initial begin
    nom = '{VT, VSW, HSW, -1};
    tbl[0] = '{nom, nom, nom, 1'b1, 4'b0000, 16'd20, 16'd3, 16'd40, 16'd6};
    tbl[1] = '{nom, '{VT, VSW, HSW, 7}, nom, 1'b0, 4'b0001, 16'd20, 16'd3, 16'd40, 16'd6};
    tbl[2] = '{nom, '{19, 2, HSW, -1}, nom, 1'b0, 4'b1100, 16'd19, 16'd2, 16'd40, 16'd6};
    tbl[3] = '{'{VT, VSW, 5, -1}, nom, nom, 1'b0, 4'b0010, 16'd20, 16'd3, 16'd40, 16'd6};
    tbl[4] = '{nom, nom, '{17, 1, 8, 3}, 1'b0, 4'b0000, 16'd20, 16'd3, 16'd40, 16'd6};
    tbl[5] = '{nom, '{VT, VSW, HSW, 19}, nom, 1'b0, 4'b0001, 16'd20, 16'd3, 16'd41, 16'd6};
    tbl[6] = '{'{VT, VSW, HSW, 0}, nom, nom, 1'b0, 4'b0000, 16'd20, 16'd3, 16'd40, 16'd6};

    cref = '0;
    for (int k = 0; k < HACT * VACT; k++) cref = {cref[30:0], cref[31]} ^ 32'h0000_0FFF;

    rst = 1'b1; start = 1'b0; hs = ~POL; vs = ~POL; r = '0; g = '0; b = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_zero("reset");

    // syncs stuck asserted while armed: no edges, nothing measured
    hs = POL; vs = POL;
    repeat (5) tick();
    start = 1'b1; tick(); start = 1'b0;
    m_armed = 1; m_meas = 0; m_err = '0; m_cnt = 0;
    repeat (300) tick();
    check("stuck_busy", 32'(busy), 32'd1);
    check("stuck_err", 32'(err), 32'd0);
    check("stuck_fv_count", 32'(fv_seen), 32'd0);
    check("stuck_frame_cnt", 32'(frame_cnt), 32'd0);
    idle(5);

    for (int s = 0; s < 7; s++) begin
      cks_hist.delete();
      do_start();
      check("start_busy", 32'(busy), 32'd1);
      drive_frame(tbl[s].f0, 1'b0, tbl[s].cpx);
      drive_frame(tbl[s].f1, 1'b0, tbl[s].cpx);
      drive_frame(tbl[s].f2, 1'b0, tbl[s].cpx);
      idle(3);
      check_final("tbl");
      check("tbl_err", 32'(err), 32'(tbl[s].e_err));
      check("tbl_lines", 32'(lines), 32'(tbl[s].e_lines));
      check("tbl_vswidth", 32'(vswidth), 32'(tbl[s].e_vsw));
      check("tbl_hperiod", 32'(hperiod), 32'(tbl[s].e_hper));
      check("tbl_hswidth", 32'(hswidth), 32'(tbl[s].e_hsw));
      if (tbl[s].cpx) begin
        check("const_cks_count", 32'(cks_hist.size()), 32'd2);
        for (int k = 0; k < cks_hist.size(); k++) check("const_cks", cks_hist[k], cref);
      end
    end

    // start coincident with a vsync edge in MEAS re-arms without a frame
    do_start();
    drive_frame(nom, 1'b0, 1'b0);
    fv0 = fv_seen;
    drive_frame(nom, 1'b1, 1'b0);
    check("restart_fv_count", 32'(fv_seen), 32'(fv0));
    check("restart_frame_cnt", 32'(frame_cnt), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_err", 32'(err), 32'd0);
    for (int k = 0; k < 3; k++) drive_frame(nom, 1'b0, 1'b0);
    idle(3);
    check_final("restart");

    // reset in the middle of a frame drops everything until a new start
    do_start();
    drive_frame(nom, 1'b0, 1'b0);
    drive_frame('{10, VSW, HSW, -1}, 1'b0, 1'b0);
    hs = POL; rst = 1'b1;
    tick();
    rst = 1'b0; hs = ~POL;
    m_armed = 0; m_meas = 0;
    check_zero("midrst");
    fv0 = fv_seen;
    for (int k = 0; k < 3; k++) drive_frame(nom, 1'b0, 1'b0);
    check("midrst_fv_count", 32'(fv_seen), 32'(fv0));
    check_zero("midrst_after");

    // randomized frame timings against the model
    for (int run = 0; run < 4; run++) begin
      do_start();
      for (int k = 0; k < 3; k++) begin
        fx[k].n = int'($urandom_range(VT + 1, VT - 1));
        fx[k].vsw = int'($urandom_range(4, 1));
        fx[k].hsw = int'($urandom_range(8, 4));
        fx[k].long_line = ($urandom_range(2, 0) == 0) ? int'($urandom_range(fx[k].n - 1, 0)) : -1;
      end
      for (int k = 0; k < 3; k++) drive_frame(fx[k], 1'b0, 1'b0);
      idle(3);
      check_final("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
